// File: rtl/aq_gemac_udp_tx_if.sv
// Payload stream and external TX buffer handshake bundle
// for the UDP/IPv4 frame builder.
interface aq_gemac_udp_tx_if;
  logic        PAY_VALID;
  logic [31:0] PAY_DATA;
  logic        PAY_READY;
  logic        ETX_BUFF_WE;
  logic        ETX_BUFF_START;
  logic        ETX_BUFF_END;
  logic [31:0] ETX_BUFF_DATA;
  logic        ETX_BUFF_READY;
  logic        ETX_BUFF_FULL;

  modport master (
    input  PAY_VALID,
    input  PAY_DATA,
    output PAY_READY,
    output ETX_BUFF_WE,
    output ETX_BUFF_START,
    output ETX_BUFF_END,
    output ETX_BUFF_DATA,
    input  ETX_BUFF_READY,
    input  ETX_BUFF_FULL
  );

  modport slave (
    output PAY_VALID,
    output PAY_DATA,
    input  PAY_READY,
    input  ETX_BUFF_WE,
    input  ETX_BUFF_START,
    input  ETX_BUFF_END,
    input  ETX_BUFF_DATA,
    output ETX_BUFF_READY,
    output ETX_BUFF_FULL
  );
endinterface

// File: rtl/aq_gemac_udp_tx.sv
// UDP/IPv4 frame builder: length word, 42-byte header with
// IPv4 checksum, then payload realigned by two bytes.
module aq_gemac_udp_tx #(
  parameter logic [7:0] TTL         = 8'h40,
  parameter int         MAX_PAYLOAD = 1472
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [47:0] MAC_ADDRESS,
  input  logic [31:0] IP_ADDRESS,
  input  logic [47:0] DST_MAC,
  input  logic [31:0] DST_IP,
  input  logic [15:0] SRC_PORT,
  input  logic [15:0] DST_PORT,
  input  logic        REQ,
  input  logic [10:0] LENGTH,
  output logic        BUSY,
  output logic        DONE,
  output logic        LEN_ERR,
  aq_gemac_udp_tx_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CSUM  = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_PAY   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]  state_q;
  logic [47:0] smac_q, dmac_q;
  logic [31:0] sip_q, dip_q;
  logic [15:0] sport_q, dport_q;
  logic [10:0] len_q;
  logic [15:0] id_q, cs_q, carry_q;
  logic [17:0] acc_q;
  logic [3:0]  step_q;
  logic [8:0]  pcnt_q;
  logic        done_q, lerr_q;

  logic [15:0]  totlen, ulen, flen;
  logic [15:0]  term_a, term_b;
  logic [17:0]  acc_d;
  logic [16:0]  fold1;
  logic [15:0]  fold2;
  logic [15:0]  cs_d;
  logic [319:0] hdr;
  logic [351:0] frame;
  logic [11:0]  nw_sum;
  logic         plast;
  logic         end_in_pay;
  logic [31:0]  mask;
  logic [31:0]  pdata;

  assign totlen = 16'(len_q) + 16'd28;
  assign ulen   = 16'(len_q) + 16'd8;
  assign flen   = 16'(len_q) + 16'd42;

  always_comb begin
    term_a = 16'h0000;
    term_b = 16'h0000;
    case (step_q[2:0])
      3'd0: begin term_a = 16'h4500; term_b = totlen; end
      3'd1: begin term_a = id_q; term_b = 16'h4000; end
      3'd2: begin
        term_a = {TTL, 8'h11};
        term_b = {sip_q[7:0], sip_q[15:8]};
      end
      3'd3: begin
        term_a = {sip_q[23:16], sip_q[31:24]};
        term_b = {dip_q[7:0], dip_q[15:8]};
      end
      3'd4: term_a = {dip_q[23:16], dip_q[31:24]};
      default: ;
    endcase
  end

  // Carries are folded back on every add so 18 bits never overflow.
  assign acc_d = {2'b00, acc_q[15:0]} + {16'h0000, acc_q[17:16]}
               + {2'b00, term_a} + {2'b00, term_b};
  assign fold1 = {1'b0, acc_d[15:0]} + {15'h0000, acc_d[17:16]};
  assign fold2 = fold1[15:0] + {15'h0000, fold1[16]};
  assign cs_d  = ~fold2;

  // Byte k of the header sits at hdr[8k +: 8].
  assign hdr = {ulen[7:0], ulen[15:8], dport_q[7:0], dport_q[15:8],
                sport_q[7:0], sport_q[15:8], dip_q, sip_q,
                cs_q[7:0], cs_q[15:8], 8'h11, TTL, 8'h00, 8'h40,
                id_q[7:0], id_q[15:8], totlen[7:0], totlen[15:8],
                8'h00, 8'h45, 8'h00, 8'h08, smac_q, dmac_q};
  assign frame = {hdr, flen, 16'h0000};

  assign nw_sum     = {1'b0, len_q} + 12'd3;
  assign plast      = (pcnt_q + 9'd1) == nw_sum[10:2];
  assign end_in_pay = len_q[1] ^ len_q[0];

  always_comb begin
    mask = 32'hFFFF_FFFF;
    case (len_q[1:0])
      2'd1: mask = 32'h0000_00FF;
      2'd2: mask = 32'h0000_FFFF;
      2'd3: mask = 32'h00FF_FFFF;
      default: ;
    endcase
  end

  assign pdata = plast ? (bus.PAY_DATA & mask) : bus.PAY_DATA;

  always_comb begin
    bus.PAY_READY      = 1'b0;
    bus.ETX_BUFF_WE    = 1'b0;
    bus.ETX_BUFF_START = 1'b0;
    bus.ETX_BUFF_END   = 1'b0;
    bus.ETX_BUFF_DATA  = 32'h0000_0000;
    unique case (1'b1)
      state_q == S_HDR: begin
        bus.ETX_BUFF_WE    = !bus.ETX_BUFF_FULL;
        bus.ETX_BUFF_START = !bus.ETX_BUFF_FULL && step_q == 4'd0;
        bus.ETX_BUFF_DATA  = frame[{step_q, 5'd0} +: 32];
      end
      state_q == S_PAY: begin
        bus.PAY_READY     = !bus.ETX_BUFF_FULL;
        bus.ETX_BUFF_WE   = !bus.ETX_BUFF_FULL && bus.PAY_VALID;
        bus.ETX_BUFF_END  = bus.ETX_BUFF_WE && plast && end_in_pay;
        bus.ETX_BUFF_DATA = {pdata[15:0], carry_q};
      end
      state_q == S_FLUSH: begin
        bus.ETX_BUFF_WE   = !bus.ETX_BUFF_FULL;
        bus.ETX_BUFF_END  = !bus.ETX_BUFF_FULL;
        bus.ETX_BUFF_DATA = {16'h0000, carry_q};
      end
      default: ;
    endcase
  end

  assign BUSY    = state_q != S_IDLE;
  assign DONE    = done_q;
  assign LEN_ERR = lerr_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      smac_q  <= '0;
      dmac_q  <= '0;
      sip_q   <= '0;
      dip_q   <= '0;
      sport_q <= '0;
      dport_q <= '0;
      len_q   <= '0;
      id_q    <= '0;
      cs_q    <= '0;
      carry_q <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      pcnt_q  <= '0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      lerr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (REQ && bus.ETX_BUFF_READY) begin
            if (LENGTH != 11'd0 && LENGTH <= 11'(MAX_PAYLOAD)) begin
              smac_q  <= MAC_ADDRESS;
              dmac_q  <= DST_MAC;
              sip_q   <= IP_ADDRESS;
              dip_q   <= DST_IP;
              sport_q <= SRC_PORT;
              dport_q <= DST_PORT;
              len_q   <= LENGTH;
              acc_q   <= '0;
              step_q  <= '0;
              state_q <= S_CSUM;
            end else begin
              lerr_q <= 1'b1;
            end
          end
        end
        S_CSUM: begin
          acc_q  <= acc_d;
          step_q <= step_q + 4'd1;
          if (step_q == 4'd4) begin
            cs_q    <= cs_d;
            step_q  <= '0;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (!bus.ETX_BUFF_FULL) begin
            step_q <= step_q + 4'd1;
            if (step_q == 4'd10) begin
              step_q  <= '0;
              carry_q <= '0;
              pcnt_q  <= '0;
              state_q <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (bus.PAY_VALID && !bus.ETX_BUFF_FULL) begin
            carry_q <= pdata[31:16];
            pcnt_q  <= pcnt_q + 9'd1;
            if (plast) begin
              if (end_in_pay) begin
                done_q  <= 1'b1;
                id_q    <= id_q + 16'd1;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          if (!bus.ETX_BUFF_FULL) begin
            done_q  <= 1'b1;
            id_q    <= id_q + 16'd1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_gemac_udp_tx.sv
// Bench for aq_gemac_udp_tx: byte-level frame model, per-write
// compare process and literal checks on key words.
module tb_aq_gemac_udp_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] mac_address = 48'h151413121110;
  logic [31:0] ip_address  = 32'h0101A8C0;
  logic [47:0] dst_mac     = 48'hFFFFFFFFFFFF;
  logic [31:0] dst_ip      = 32'h1001A8C0;
  logic [15:0] src_port    = 16'd1234;
  logic [15:0] dst_port    = 16'd5678;
  logic        req;
  logic [10:0] length;
  logic        busy, done, len_err;

  aq_gemac_udp_tx_if bus_if ();

  aq_gemac_udp_tx dut (
    .CLK         (clk),
    .RST         (rst),
    .MAC_ADDRESS (mac_address),
    .IP_ADDRESS  (ip_address),
    .DST_MAC     (dst_mac),
    .DST_IP      (dst_ip),
    .SRC_PORT    (src_port),
    .DST_PORT    (dst_port),
    .REQ         (req),
    .LENGTH      (length),
    .BUSY        (busy),
    .DONE        (done),
    .LEN_ERR     (len_err),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  logic end_prev = 1'b0;
  logic [33:0] exp_q[$];
  logic [31:0] cap[$];
  logic [31:0] pay_q[$];
  int pidx = 0;
  int cyc = 0;
  bit full_mode = 0;
  bit gap_mode = 0;
  logic [15:0] model_id = 16'h0000;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] expv);
    cmp_cnt++;
    if (got !== expv) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", nm, got, expv);
    end
  endtask

  // Expected frame: header bytes, then payload bytes, packed
  // little-endian into words after the length word.
  task automatic load_frame(input int n);
    logic [7:0]  hb[42];
    logic [7:0]  bv;
    logic [31:0] s;
    logic [31:0] w;
    logic [15:0] cs, totlen, ulen;
    int nw, idx;
    totlen = 16'(28 + n);
    ulen   = 16'(8 + n);
    for (int i = 0; i < 6; i++) begin
      hb[i]     = dst_mac[8*i +: 8];
      hb[6 + i] = mac_address[8*i +: 8];
    end
    hb[12] = 8'h08; hb[13] = 8'h00; hb[14] = 8'h45; hb[15] = 8'h00;
    hb[16] = totlen[15:8]; hb[17] = totlen[7:0];
    hb[18] = model_id[15:8]; hb[19] = model_id[7:0];
    hb[20] = 8'h40; hb[21] = 8'h00; hb[22] = 8'h40; hb[23] = 8'h11;
    hb[24] = 8'h00; hb[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      hb[26 + i] = ip_address[8*i +: 8];
      hb[30 + i] = dst_ip[8*i +: 8];
    end
    hb[34] = src_port[15:8]; hb[35] = src_port[7:0];
    hb[36] = dst_port[15:8]; hb[37] = dst_port[7:0];
    hb[38] = ulen[15:8]; hb[39] = ulen[7:0];
    hb[40] = 8'h00; hb[41] = 8'h00;
    s = 0;
    for (int k = 14; k < 34; k += 2) s = s + {16'h0, hb[k], hb[k+1]};
    while (s > 32'h0000FFFF) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    hb[24] = cs[15:8]; hb[25] = cs[7:0];
    exp_q.push_back({1'b1, 1'b0, 16'(42 + n), 16'h0000});
    nw = (42 + n + 3) / 4;
    for (int j = 0; j < nw; j++) begin
      w = 0;
      for (int b = 0; b < 4; b++) begin
        idx = 4*j + b;
        if (idx < 42) bv = hb[idx];
        else if (idx < 42 + n) bv = 8'(8'h61 + idx - 42);
        else bv = 8'h00;
        w[8*b +: 8] = bv;
      end
      exp_q.push_back({1'b0, (j == nw - 1), w});
    end
    for (int k = 0; k < (n + 3) / 4; k++) begin
      w = 0;
      for (int b = 0; b < 4; b++)
        w[8*b +: 8] = (4*k + b < n) ? 8'(8'h61 + 4*k + b) : 8'hEE;
      pay_q.push_back(w);
    end
    model_id = model_id + 16'd1;
  endtask

  task automatic send_req(input int n);
    @(posedge clk); #1;
    req = 1'b1; length = 11'(n);
    @(posedge clk); #1;
    req = 1'b0;
    chk("busy_after_req", {63'h0, busy}, 64'd1);
  endtask

  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int k = 0; k < 3000 && done_cnt == start; k++) @(posedge clk);
    #1;
    chk("done_seen", {63'h0, done_cnt != start}, 64'd1);
    chk("busy_after_done", {63'h0, busy}, 64'd0);
    chk("words_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_bad(input int n);
    @(posedge clk); #1;
    req = 1'b1; length = 11'(n);
    @(posedge clk); #1;
    req = 1'b0;
    chk("len_err_pulse", {62'h0, len_err, busy}, 64'd2);
    @(posedge clk); #1;
    chk("len_err_once", {63'h0, len_err}, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("reject_no_we", 64'(cap.size()), 64'd0);
  endtask

  // Source/sink driver: inputs move #1 after each edge.
  initial begin
    bus_if.PAY_VALID      = 1'b0;
    bus_if.PAY_DATA       = 32'h0;
    bus_if.ETX_BUFF_READY = 1'b1;
    bus_if.ETX_BUFF_FULL  = 1'b0;
    forever begin
      @(posedge clk);
      if (bus_if.PAY_VALID && bus_if.PAY_READY) pidx++;
      cyc++;
      #1;
      bus_if.ETX_BUFF_FULL = full_mode ? ~bus_if.ETX_BUFF_FULL : 1'b0;
      bus_if.PAY_VALID = (pidx < pay_q.size()) &&
                         !(gap_mode && (cyc % 3 == 0));
      bus_if.PAY_DATA  = (pidx < pay_q.size()) ? pay_q[pidx] : 32'h0;
    end
  end

  always @(negedge clk) begin
    if (bus_if.ETX_BUFF_WE) begin
      cap.push_back(bus_if.ETX_BUFF_DATA);
      cmp_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL etx_extra got=%h exp=none", bus_if.ETX_BUFF_DATA);
      end else begin
        logic [33:0] e, g;
        e = exp_q.pop_front();
        g = {bus_if.ETX_BUFF_START, bus_if.ETX_BUFF_END,
             bus_if.ETX_BUFF_DATA};
        if (g !== e) begin
          err_cnt++;
          $display("FAIL etx_word got=%h exp=%h", g, e);
        end
      end
    end
    if (done || end_prev) begin
      cmp_cnt++;
      if (done !== end_prev) begin
        err_cnt++;
        $display("FAIL done_pulse got=%b exp=%b", done, end_prev);
      end
    end
    if (done) done_cnt++;
    end_prev = bus_if.ETX_BUFF_WE && bus_if.ETX_BUFF_END;
  end

  initial begin
    int wc[4];
    wc[0] = 12; wc[1] = 12; wc[2] = 13; wc[3] = 13;
    rst = 1'b0; req = 1'b0; length = 11'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {20'h0, busy, done, len_err, bus_if.PAY_READY, bus_if.ETX_BUFF_WE,
         bus_if.ETX_BUFF_START, bus_if.ETX_BUFF_END, bus_if.ETX_BUFF_DATA},
        64'd0);
    rst = 1'b1;

    cap.delete();
    load_frame(4);
    send_req(4);
    wait_done();
    chk("basic_count", 64'(cap.size()), 64'd13);
    if (cap.size() == 13) begin
      chk("basic_w0", 64'(cap[0]), 64'h002E0000);
      chk("basic_w1", 64'(cap[1]), 64'hFFFFFFFF);
      chk("basic_cs", 64'(cap[7][15:0]), 64'h6BB7);
      chk("basic_w11", 64'(cap[11]), 64'h62610000);
      chk("basic_w12", 64'(cap[12]), 64'h00006463);
    end

    cap.delete();
    load_frame(4);
    send_req(4);
    wait_done();
    chk("second_count", 64'(cap.size()), 64'd13);
    if (cap.size() == 13) begin
      chk("second_id_cs", 64'(cap[5][31:16]), 64'h0100);
      chk("second_cs", 64'(cap[7][15:0]), 64'h6AB7);
      chk("second_w12", 64'(cap[12]), 64'h00006463);
    end

    cap.delete();
    full_mode = 1; gap_mode = 1;
    load_frame(5);
    send_req(5);
    wait_done();
    full_mode = 0; gap_mode = 0;
    chk("bp_count", 64'(cap.size()), 64'd13);
    if (cap.size() == 13) begin
      chk("bp_w11", 64'(cap[11]), 64'h62610000);
      chk("bp_w12", 64'(cap[12]), 64'h00656463);
    end

    repeat (3) @(posedge clk);
    cap.delete();
    send_bad(0);
    send_bad(1473);

    @(posedge clk); #1;
    bus_if.ETX_BUFF_READY = 1'b0;
    req = 1'b1; length = 11'd2;
    repeat (5) @(posedge clk);
    #1;
    chk("not_ready_idle", {63'h0, busy}, 64'd0);
    load_frame(2);
    bus_if.ETX_BUFF_READY = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("ready_accept", {63'h0, busy}, 64'd1);
    wait_done();
    chk("ready_count", 64'(cap.size()), 64'd12);

    for (int n = 1; n <= 4; n++) begin
      cap.delete();
      load_frame(n);
      send_req(n);
      wait_done();
      chk($sformatf("sweep_count_n%0d", n), 64'(cap.size()),
          64'(wc[n-1]));
    end

    cap.delete();
    load_frame(4);
    send_req(4);
    for (int k = 0; k < 100 && cap.size() < 3; k++) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midframe_reset",
        {20'h0, busy, done, len_err, bus_if.PAY_READY, bus_if.ETX_BUFF_WE,
         bus_if.ETX_BUFF_START, bus_if.ETX_BUFF_END, bus_if.ETX_BUFF_DATA},
        64'd0);
    exp_q.delete();
    pay_q.delete();
    pidx = 0;
    model_id = 16'h0000;
    end_prev = 1'b0;
    rst = 1'b1;
    cap.delete();
    load_frame(4);
    send_req(4);
    wait_done();
    chk("post_reset_count", 64'(cap.size()), 64'd13);
    if (cap.size() == 13) begin
      chk("post_reset_cs", 64'(cap[7][15:0]), 64'h6BB7);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
